// File: rtl/data_bus_responder.sv
// Data-bus responder: zero-latency RAM, TX FIFO and cycle counter on one bus.
// Ports: clk, reset (async low), WE/address_to_mem/data_to_mem/data_from_mem, out_*.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'h0000_F000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] TX_ADDR = MMIO_BASE;
  localparam logic [31:0] ST_ADDR = MMIO_BASE + 32'd4;
  localparam logic [31:0] CY_ADDR = MMIO_BASE + 32'd8;

  logic [31:0] mem  [RAM_WORDS];
  logic [31:0] fifo [4];
  logic [1:0]  wp, rp;
  logic [2:0]  count;
  logic        ovf;
  logic [31:0] cycle;

  logic [31:0]   wa;
  logic [AW-1:0] ridx;
  logic is_ram, is_tx, is_st, is_cyc;
  logic full, empty, pop, push, ovf_set;

  assign wa     = {address_to_mem[31:2], 2'b00};
  assign ridx   = address_to_mem[AW+1:2];
  assign is_ram = address_to_mem < RAM_BYTES;
  assign is_tx  = wa == TX_ADDR;
  assign is_st  = wa == ST_ADDR;
  assign is_cyc = wa == CY_ADDR;

  assign full    = count == 3'd4;
  assign empty   = count == 3'd0;
  assign pop     = !empty && out_ready;
  // A pop frees the slot this edge, so a full FIFO still accepts.
  assign push    = WE && is_tx && (!full || pop);
  assign ovf_set = WE && is_tx && full && !pop;

  assign out_valid = !empty;
  assign out_data  = fifo[rp];

  always_ff @(posedge clk) begin
    if (WE && is_ram) mem[ridx] <= data_to_mem;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= data_to_mem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      count <= 3'd0;
      ovf   <= 1'b0;
      cycle <= 32'd0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      if (ovf_set)            ovf <= 1'b1;
      else if (WE && is_st)   ovf <= 1'b0;
      cycle <= (WE && is_cyc) ? data_to_mem : cycle + 32'd1;
    end
  end

  always_comb begin
    data_from_mem = 32'd0;
    unique case (1'b1)
      is_ram: data_from_mem = mem[ridx];
      is_st:  data_from_mem = {26'd0, ovf, empty, full, count};
      is_cyc: data_from_mem = cycle;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder.
// Scoreboard queue tracks words expected on the FIFO output.
module tb_data_bus_responder;

  localparam logic [31:0] TX = 32'h0000_F000;
  localparam logic [31:0] ST = 32'h0000_F004;
  localparam logic [31:0] CY = 32'h0000_F008;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  data_bus_responder dut (
    .clk(clk),
    .reset(reset),
    .WE(WE),
    .address_to_mem(address_to_mem),
    .data_to_mem(data_to_mem),
    .data_from_mem(data_from_mem),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    WE = 1'b1;
    address_to_mem = a;
    data_to_mem = d;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  // Push with out_ready low; scoreboard only records accepted words.
  task automatic push(input logic [31:0] d);
    if (exp_q.size() < 4) exp_q.push_back(d);
    drive_wr(TX, d);
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        failures++;
        $display("FAIL drain_word got valid=%b data=%h want valid=1 data=%h",
                 out_valid, out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_end got left=%0d valid=%b want left=0 valid=0",
               exp_q.size(), out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    #3;
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h10 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got %h/%b want 00000010/0", data_from_mem, out_valid);
    end
    address_to_mem = CY;
    #1;
    checks++;
    if (data_from_mem !== 32'd0) begin
      failures++;
      $display("FAIL reset_cycle got %h want 0", data_from_mem);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_from_mem !== 32'd1) begin
      failures++;
      $display("FAIL first_edge_cycle got %h want 1", data_from_mem);
    end
  endtask

  task automatic test_ram;
    drive_wr(32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    address_to_mem = 32'h10;
    #1;
    checks++;
    if (data_from_mem !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ram_read got %h want deadbeef", data_from_mem);
    end
    address_to_mem = 32'h13;
    #1;
    checks++;
    if (data_from_mem !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ram_read_unaligned got %h want deadbeef", data_from_mem);
    end
    @(negedge clk);
    WE = 1'b1;
    address_to_mem = 32'h10;
    data_to_mem = 32'h1234_5678;
    #1;
    checks++;
    if (data_from_mem !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ram_old_word got %h want deadbeef", data_from_mem);
    end
    @(posedge clk);
    #1;
    WE = 1'b0;
    #1;
    checks++;
    if (data_from_mem !== 32'h1234_5678) begin
      failures++;
      $display("FAIL ram_new_word got %h want 12345678", data_from_mem);
    end
    drive_wr(32'h10, 32'hDEAD_BEEF);
    drive_wr(32'hFC, 32'hA5A5_5A5A);
    @(negedge clk);
    address_to_mem = 32'hFC;
    #1;
    checks++;
    if (data_from_mem !== 32'hA5A5_5A5A) begin
      failures++;
      $display("FAIL ram_last_word got %h want a5a55a5a", data_from_mem);
    end
    address_to_mem = 32'h100;
    #1;
    checks++;
    if (data_from_mem !== 32'd0) begin
      failures++;
      $display("FAIL past_ram_read got %h want 0", data_from_mem);
    end
  endtask

  task automatic test_fifo_overflow;
    out_ready = 1'b0;
    push(32'd1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd1) begin
      failures++;
      $display("FAIL push_latency got %b/%h want 1/1", out_valid, out_data);
    end
    for (int i = 2; i <= 4; i++) push(32'(i));
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h0C) begin
      failures++;
      $display("FAIL status_full got %h want 0c", data_from_mem);
    end
    push(32'd5);
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h2C) begin
      failures++;
      $display("FAIL status_ovf got %h want 2c", data_from_mem);
    end
    address_to_mem = TX;
    #1;
    checks++;
    if (data_from_mem !== 32'd0) begin
      failures++;
      $display("FAIL txdata_read got %h want 0", data_from_mem);
    end
    address_to_mem = ST;
    drain();
    #1;
    checks++;
    if (data_from_mem !== 32'h30) begin
      failures++;
      $display("FAIL status_empty_ovf got %h want 30", data_from_mem);
    end
  endtask

  task automatic test_ovf_clear;
    drive_wr(ST, 32'd0);
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h10) begin
      failures++;
      $display("FAIL ovf_clear got %h want 10", data_from_mem);
    end
    for (int i = 0; i < 5; i++) push(32'h100 + 32'(i));
    drive_wr(ST, 32'd0);
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h0C) begin
      failures++;
      $display("FAIL ovf_clear_full got %h want 0c", data_from_mem);
    end
    push(32'h200);
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h2C) begin
      failures++;
      $display("FAIL ovf_reset_again got %h want 2c", data_from_mem);
    end
    drain();
    drive_wr(ST, 32'd0);
  endtask

  task automatic test_back_to_back;
    push(32'd6);
    push(32'd7);
    push(32'd8);
    push(32'd10);
    @(negedge clk);
    checks++;
    if (out_data !== exp_q[0]) begin
      failures++;
      $display("FAIL b2b_head got %h want %h", out_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    WE = 1'b1;
    address_to_mem = TX;
    data_to_mem = 32'd9;
    exp_q.push_back(32'd9);
    @(posedge clk);
    #1;
    WE = 1'b0;
    out_ready = 1'b0;
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h0C) begin
      failures++;
      $display("FAIL b2b_status got %h want 0c", data_from_mem);
    end
    drain();
    #1;
    checks++;
    if (data_from_mem !== 32'h10) begin
      failures++;
      $display("FAIL b2b_after got %h want 10", data_from_mem);
    end
  endtask

  task automatic test_cycle;
    logic [31:0] exp_c [4];
    exp_c[0] = 32'hFFFF_FFFE;
    exp_c[1] = 32'hFFFF_FFFF;
    exp_c[2] = 32'h0000_0000;
    exp_c[3] = 32'h0000_0001;
    drive_wr(CY, 32'hFFFF_FFFE);
    address_to_mem = CY;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
      end
      #1;
      checks++;
      if (data_from_mem !== exp_c[i]) begin
        failures++;
        $display("FAIL cycle_%0d got %h want %h", i, data_from_mem, exp_c[i]);
      end
    end
  endtask

  task automatic test_unmapped;
    drive_wr(32'h0000_8000, 32'h5555_5555);
    drive_wr(TX + 32'hC, 32'h5555_5555);
    @(negedge clk);
    address_to_mem = 32'h0000_8000;
    #1;
    checks++;
    if (data_from_mem !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_read got %h want 0", data_from_mem);
    end
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h10 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_side got %h/%b want 10/0", data_from_mem, out_valid);
    end
  endtask

  task automatic test_async_reset;
    push(32'h77);
    push(32'h88);
    @(negedge clk);
    #2;
    reset = 1'b0;
    address_to_mem = ST;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_from_mem !== 32'h10) begin
      failures++;
      $display("FAIL async_reset got %b/%h want 0/10", out_valid, data_from_mem);
    end
    address_to_mem = 32'h10;
    #1;
    checks++;
    if (data_from_mem !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ram_kept got %h want deadbeef", data_from_mem);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    address_to_mem = CY;
    @(posedge clk);
    #1;
    checks++;
    if (data_from_mem !== 32'd1) begin
      failures++;
      $display("FAIL cycle_after_reset got %h want 1", data_from_mem);
    end
    address_to_mem = ST;
    #1;
    checks++;
    if (data_from_mem !== 32'h10) begin
      failures++;
      $display("FAIL status_after_reset got %h want 10", data_from_mem);
    end
  endtask

  initial begin
    reset = 1'b0;
    WE = 1'b0;
    address_to_mem = 32'd0;
    data_to_mem = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_ovf_clear();
    test_back_to_back();
    test_cycle();
    test_unmapped();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 The block SHALL have the parameter RAM_WORDS, default 64, giving the number of 32-bit data RAM words (power of two, 4..1024).
REQ-002 The block SHALL have the parameter MMIO_BASE, default 32'h0000_F000, giving the base byte address of the MMIO window (word aligned, at or above RAM_WORDS*4).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low (0 = reset asserted).
REQ-005 The block SHALL have the port WE, input, 1 bit: processor write strobe for the current cycle.
REQ-006 The block SHALL have the port address_to_mem, input, 32 bits: processor byte address; bits [1:0] ignored.
REQ-007 The block SHALL have the port data_to_mem, input, 32 bits: processor write data.
REQ-008 The block SHALL have the port data_from_mem, output, 32 bits: read data returned to the processor.
REQ-009 The block SHALL have the port out_data, output, 32 bits: FIFO head word.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: FIFO is non-empty.
REQ-011 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts out_data.

Function
REQ-012 The address map SHALL be:
- RAM: address < RAM_WORDS*4, word index address[log2(RAM_WORDS)+1:2].
- TXDATA: MMIO_BASE+0x0.
- STATUS: MMIO_BASE+0x4.
- CYCLE: MMIO_BASE+0x8.
- Unmapped: all other addresses.
REQ-013 data_from_mem SHALL be combinational from address_to_mem and current state in the same cycle, with zero latency, so a single-cycle processor can load without stalling.
REQ-014 Reads SHALL return:
- RAM: the addressed word.
- TXDATA: 0.
- STATUS: {26'b0, ovf, empty, full, count[2:0]}.
- CYCLE: the counter value.
- Unmapped: 0.
REQ-015 A RAM write SHALL update the addressed word at the rising clk edge when WE=1; a same-address read in the same cycle SHALL return the old word.
REQ-016 The FIFO SHALL be 4 entries x 32 bits, with count 0..4, full = (count==4) and empty = (count==0).
REQ-017 A push SHALL occur when WE=1, the address is TXDATA and the FIFO is not full, and SHALL enqueue data_to_mem.
REQ-018 A pop SHALL occur when out_valid=1 and out_ready=1, and SHALL discard the head.
REQ-019 out_valid SHALL be !empty, and out_data SHALL be the head word, both driven from registers or storage with no combinational path from WE.
REQ-020 A word pushed at edge N SHALL appear on out_valid/out_data after edge N when the FIFO was empty (1-cycle latency).
REQ-021 A push and a pop in the same cycle SHALL both take effect and leave count unchanged, including when count==4; ovf SHALL NOT be set in that case.
REQ-022 A push attempted while full without a simultaneous pop SHALL drop the word and set sticky ovf.
REQ-023 A pop while empty SHALL be impossible, since out_valid=0; out_ready SHALL be ignored while empty.
REQ-024 The read and write pointers SHALL be 2 bits and SHALL wrap 3->0.
REQ-025 Any write to STATUS SHALL clear ovf at the edge; if an overflow occurs in the same cycle, set SHALL win.
REQ-026 The cycle counter SHALL be 32 bits and SHALL increment by 1 every clk edge, wrapping from 32'hFFFF_FFFF to 0.
REQ-027 A write to CYCLE SHALL load data_to_mem at that edge, instead of incrementing, and SHALL increment from that value at following edges.
REQ-028 Writes to TXDATA while full, and writes to unmapped addresses, SHALL have no other side effect.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for clk, set count=0, both pointers=0, ovf=0, cycle counter=0, and out_valid=0.
REQ-030 RAM contents SHALL NOT be affected by reset.
REQ-031 Reset asserted mid-operation SHALL discard all FIFO contents, and no pop or push SHALL be reported for that cycle.
REQ-032 After reset deasserts, the first clk edge SHALL increment the cycle counter to 1.

Verification
REQ-033 RAM write 0xDEADBEEF to 0x10, then read 0x10 -> data_from_mem=0xDEADBEEF in the read cycle; read 0x13 -> same word.
REQ-034 Push 1,2,3,4 with out_ready=0 -> STATUS=0x0C (full, count 4); push 5 -> STATUS=0x2C (ovf set); raise out_ready -> out_data sequence 1,2,3,4, then out_valid=0 and STATUS=0x30.
REQ-035 With the FIFO full and out_ready=1, push 9 in the same cycle as the pop -> count stays 4, ovf stays 0, and 9 is delivered last.
REQ-036 Write 0xFFFF_FFFE to CYCLE -> subsequent reads show 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001 on successive cycles.
REQ-037 Assert reset=0 between clk edges with the FIFO holding 2 words -> out_valid=0 and STATUS=0x10 before the next edge; a previously written RAM word reads unchanged.
REQ-038 Write STATUS while an overflow push occurs in the same cycle -> ovf=1 afterwards.
